// File: rtl/clock_reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// clock_reset_sequencer_pkg
// Shared clocking definitions for the board-clock bring-up logic:
//   - sequencer state encoding
//   - default timing constants (cycles of the 33 MHz board clock)
//   - counter-width helper sized from the longest timing interval
// -----------------------------------------------------------------------------
package clock_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 33000;  // ~1 ms at 33 MHz
    localparam int unsigned DEF_SETTLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES   = 3;

    // Width of a counter that must reach (longest interval - 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clock_reset_sequencer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for level signals crossing into i_clk's domain.
// Output lags the input by two i_clk edges. Both flops clear to 0 on reset.
// Ports:
//   i_clk  destination clock
//   i_rst  asynchronous, active-high reset
//   i_d    asynchronous input
//   o_q    synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: the reset appears in the sensitivity list so it takes effect
    // without a clock edge; state updates use <= so both flops sample
    // their inputs from before the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clock_reset_sequencer.sv
// -----------------------------------------------------------------------------
// clock_reset_sequencer
// Brings up the clock controller from the raw board clock and supervises it:
// pulses the controller reset, waits for lock with a timeout and bounded
// retries, requires lock to be stable for a settle period before releasing
// the system reset, and restarts from scratch whenever lock is lost.
// Ports:
//   clk_33      board clock, sole clock
//   rst         asynchronous, active-high reset
//   locked      controller lock, asynchronous to clk_33
//   clkgen_rst  reset to the clock controller
//   sys_rst     design-wide reset, low only in RUN
//   ready       high only in RUN
//   fault       latched bring-up failure (cleared only by rst)
//   retries     failed attempts in the current bring-up
//   loss_count  saturating count of lock losses while in RUN
// -----------------------------------------------------------------------------
module clock_reset_sequencer
    import clock_reset_sequencer_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic       clk_33,
    input  logic       rst,
    input  logic       locked,
    output logic       clkgen_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retries,
    output logic [7:0] loss_count
);

    localparam int unsigned CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_retries;
    logic [3:0]    w_retries_nxt;
    logic [7:0]    r_loss_count;
    logic [7:0]    w_loss_nxt;
    logic          w_fail;
    logic          w_locked_s;

    logic          r_clkgen_rst;
    logic          r_sys_rst;
    logic          r_ready;
    logic          r_fault;
    logic          w_clkgen_rst_nxt;
    logic          w_sys_rst_nxt;
    logic          w_ready_nxt;
    logic          w_fault_nxt;

    sync_2ff #(.WIDTH(1)) u_locked_sync (
        .i_clk (clk_33),
        .i_rst (rst),
        .i_d   (locked),
        .o_q   (w_locked_s)
    );

    // State register. Outputs are registered from the decode of the next
    // state, so they always agree with r_state without a cycle of lag.
    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            r_state      <= ST_HOLD;
            r_cnt        <= '0;
            r_retries    <= '0;
            r_loss_count <= '0;
            r_clkgen_rst <= 1'b1;
            r_sys_rst    <= 1'b1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retries    <= w_retries_nxt;
            r_loss_count <= w_loss_nxt;
            r_clkgen_rst <= w_clkgen_rst_nxt;
            r_sys_rst    <= w_sys_rst_nxt;
            r_ready      <= w_ready_nxt;
            r_fault      <= w_fault_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retries_nxt = r_retries;
        w_loss_nxt    = r_loss_count;
        w_fail        = 1'b0;

        unique case (r_state)
            ST_HOLD: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so a lock arriving on the timeout
                // cycle still counts as success.
                if (w_locked_s) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_fail = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (!w_locked_s) begin
                    w_fail = 1'b1;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_cnt_nxt     = '0;
                    w_retries_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt   = ST_HOLD;
                    w_cnt_nxt     = '0;
                    w_retries_nxt = '0;
                    if (r_loss_count != 8'hFF) begin
                        w_loss_nxt = r_loss_count + 8'd1;
                    end
                end
            end
            ST_FAULT: begin
                // Terminal until rst.
            end
            default: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase

        // A failed attempt either retries from HOLD or gives up; retries
        // keeps its final value in FAULT.
        if (w_fail) begin
            w_cnt_nxt = '0;
            if (r_retries == RETRY_LIMIT) begin
                w_state_nxt = ST_FAULT;
            end else begin
                w_state_nxt   = ST_HOLD;
                w_retries_nxt = r_retries + 4'd1;
            end
        end
    end

    // Output decode of the upcoming state.
    always_comb begin
        w_clkgen_rst_nxt = (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_FAULT);
        w_sys_rst_nxt    = (w_state_nxt != ST_RUN);
        w_ready_nxt      = (w_state_nxt == ST_RUN);
        w_fault_nxt      = (w_state_nxt == ST_FAULT);
    end

    assign clkgen_rst = r_clkgen_rst;
    assign sys_rst    = r_sys_rst;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign retries    = r_retries;
    assign loss_count = r_loss_count;

endmodule
